// File: rtl/cnn_grid_sequencer.sv
// cnn_grid_sequencer
// Time-multiplexed ROWS x COLS cellular-network engine. One 3x3 template cell
// is applied to every grid cell in raster order, once per sweep, for a
// programmable number of synchronous sweeps. State Y is double-buffered so a
// sweep only ever reads values produced by the previous sweep; grid edges are
// zero padded. A separate result array holds the last completed run so the
// readout port stays stable while a new run is in progress.
//
// Ports:
//   clk, rst        clock / synchronous active-high reset
//   start           run request, accepted only in IDLE
//   iterations      sweep count, captured at accept
//   a_tmpl, b_tmpl  feedback / control templates, tap k at [k*WIDTH +: WIDTH]
//   bias            bias I (signed)
//   init_x          initial Y for every cell (signed), captured at accept
//   u_wr_en/addr/data  U image write port (IDLE only)
//   y_rd_addr/data  Y readout, registered, one-cycle latency
//   busy, done      run in progress / one-cycle completion pulse
module cnn_grid_sequencer #(
  parameter int WIDTH  = 9,
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int ITER_W = 8,
  localparam int N      = ROWS * COLS,
  localparam int ADDR_W = $clog2(ROWS * COLS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ITER_W-1:0]     iterations,
  input  logic [9*WIDTH-1:0]    a_tmpl,
  input  logic [9*WIDTH-1:0]    b_tmpl,
  input  logic [WIDTH-1:0]      bias,
  input  logic [2*WIDTH-1:0]    init_x,
  input  logic                  u_wr_en,
  input  logic [ADDR_W-1:0]     u_wr_addr,
  input  logic [WIDTH-1:0]      u_wr_data,
  input  logic [ADDR_W-1:0]     y_rd_addr,
  output logic [2*WIDTH-1:0]    y_rd_data,
  output logic                  busy,
  output logic                  done
);

  localparam int YW    = 2 * WIDTH;
  localparam int ACC_W = 3 * WIDTH + 5;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_SWEEP = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_FIN   = 3'd4;

  localparam logic signed [ACC_W-1:0] Y_MAX =
    $signed({{(ACC_W-YW+1){1'b0}}, {(YW-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] Y_MIN =
    $signed({{(ACC_W-YW+1){1'b1}}, {(YW-1){1'b0}}});
  localparam logic signed [ACC_W-1:0] ACC_ZERO = '0;

  // Storage
  logic signed [YW-1:0]    y_mem   [2][N];
  logic signed [YW-1:0]    res_mem [N];
  logic signed [WIDTH-1:0] u_mem   [N];

  // Control / captured run parameters
  logic [2:0]              state_reg;
  logic [ADDR_W-1:0]       idx_reg;
  logic [ADDR_W-1:0]       row_reg;
  logic [ADDR_W-1:0]       col_reg;
  logic                    rd_bank_reg;
  logic [ITER_W-1:0]       iter_left_reg;
  logic signed [WIDTH-1:0] a_coef_reg [9];
  logic signed [WIDTH-1:0] b_coef_reg [9];
  logic signed [WIDTH-1:0] bias_reg;
  logic signed [YW-1:0]    init_x_reg;
  logic                    wr_valid_reg;
  logic [ADDR_W-1:0]       wr_addr_reg;
  logic signed [YW-1:0]    wr_data_reg;
  logic [YW-1:0]           y_rd_data_reg;

  // Datapath
  logic [8:0]              tap_ok;
  logic signed [ACC_W-1:0] y_term [9];
  logic signed [ACC_W-1:0] u_term [9];
  logic signed [ACC_W-1:0] acc;
  logic signed [YW-1:0]    sat_y;

  assign busy      = (state_reg == ST_LOAD) || (state_reg == ST_SWEEP) || (state_reg == ST_DRAIN);
  assign done      = (state_reg == ST_FIN);
  assign y_rd_data = y_rd_data_reg;

  // One tap per 3x3 neighbour; gi = (dr+1)*3 + (dc+1).
  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_tap
      localparam int DR = gi / 3 - 1;
      localparam int DC = gi % 3 - 1;
      logic row_ok;
      logic col_ok;
      logic [ADDR_W-1:0] nbr_addr;

      if (DR < 0)      begin : g_r_top assign row_ok = (row_reg != '0); end
      else if (DR > 0) begin : g_r_bot assign row_ok = (row_reg != ADDR_W'(ROWS - 1)); end
      else             begin : g_r_mid assign row_ok = 1'b1; end

      if (DC < 0)      begin : g_c_lft assign col_ok = (col_reg != '0); end
      else if (DC > 0) begin : g_c_rgt assign col_ok = (col_reg != ADDR_W'(COLS - 1)); end
      else             begin : g_c_mid assign col_ok = 1'b1; end

      // Wraps for off-grid taps, but those are masked by tap_ok.
      assign nbr_addr   = ADDR_W'(int'(idx_reg) + DR * COLS + DC);
      assign tap_ok[gi] = row_ok && col_ok;
      assign y_term[gi] = tap_ok[gi]
                        ? ACC_W'(a_coef_reg[gi]) * ACC_W'(y_mem[rd_bank_reg][nbr_addr])
                        : ACC_ZERO;
      assign u_term[gi] = tap_ok[gi]
                        ? ACC_W'(b_coef_reg[gi]) * ACC_W'(u_mem[nbr_addr])
                        : ACC_ZERO;
    end
  endgenerate

  always_comb begin
    acc = ACC_W'(bias_reg);
    for (int k = 0; k < 9; k++) begin
      acc = acc + y_term[k] + u_term[k];
    end
  end

  always_comb begin
    if (acc > Y_MAX)      sat_y = {1'b0, {(YW-1){1'b1}}};
    else if (acc < Y_MIN) sat_y = {1'b1, {(YW-1){1'b0}}};
    else                  sat_y = acc[YW-1:0];
  end

  // Sequencer
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      idx_reg       <= '0;
      row_reg       <= '0;
      col_reg       <= '0;
      rd_bank_reg   <= 1'b0;
      iter_left_reg <= '0;
      bias_reg      <= '0;
      init_x_reg    <= '0;
      wr_valid_reg  <= 1'b0;
      wr_addr_reg   <= '0;
      wr_data_reg   <= '0;
      for (int k = 0; k < 9; k++) begin
        a_coef_reg[k] <= '0;
        b_coef_reg[k] <= '0;
      end
    end else begin
      wr_valid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            for (int k = 0; k < 9; k++) begin
              a_coef_reg[k] <= $signed(a_tmpl[k*WIDTH +: WIDTH]);
              b_coef_reg[k] <= $signed(b_tmpl[k*WIDTH +: WIDTH]);
            end
            bias_reg      <= $signed(bias);
            init_x_reg    <= $signed(init_x);
            iter_left_reg <= iterations;
            state_reg     <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          idx_reg   <= '0;
          row_reg   <= '0;
          col_reg   <= '0;
          state_reg <= (iter_left_reg == '0) ? ST_FIN : ST_SWEEP;
        end
        ST_SWEEP: begin
          wr_valid_reg <= 1'b1;
          wr_addr_reg  <= idx_reg;
          wr_data_reg  <= sat_y;
          if (col_reg == ADDR_W'(COLS - 1)) begin
            col_reg <= '0;
            row_reg <= row_reg + 1'b1;
          end else begin
            col_reg <= col_reg + 1'b1;
          end
          if (idx_reg == ADDR_W'(N - 1)) begin
            state_reg <= ST_DRAIN;
          end
          idx_reg <= idx_reg + 1'b1;
        end
        ST_DRAIN: begin
          // The final write of the sweep lands this cycle; the freshly
          // written bank becomes the read bank from the next cycle on.
          idx_reg       <= '0;
          row_reg       <= '0;
          col_reg       <= '0;
          rd_bank_reg   <= ~rd_bank_reg;
          iter_left_reg <= iter_left_reg - 1'b1;
          state_reg     <= (iter_left_reg > ITER_W'(1)) ? ST_SWEEP : ST_FIN;
        end
        ST_FIN:  state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Arrays and readout
  always_ff @(posedge clk) begin
    if (rst) begin
      y_rd_data_reg <= '0;
      for (int i = 0; i < N; i++) begin
        y_mem[0][i] <= '0;
        y_mem[1][i] <= '0;
        res_mem[i]  <= '0;
        u_mem[i]    <= '0;
      end
    end else begin
      y_rd_data_reg <= res_mem[y_rd_addr];
      if (state_reg == ST_IDLE && u_wr_en) begin
        u_mem[u_wr_addr] <= $signed(u_wr_data);
      end
      if (state_reg == ST_LOAD) begin
        for (int i = 0; i < N; i++) begin
          y_mem[rd_bank_reg][i] <= init_x_reg;
        end
      end
      if (wr_valid_reg) begin
        y_mem[~rd_bank_reg][wr_addr_reg] <= wr_data_reg;
      end
      // Publish the completed bank to the readout array.
      if (state_reg == ST_FIN) begin
        for (int i = 0; i < N; i++) begin
          res_mem[i] <= y_mem[rd_bank_reg][i];
        end
      end
    end
  end

endmodule

// File: tb/tb_cnn_grid_sequencer.sv
// Testbench for cnn_grid_sequencer (4x4, WIDTH=9). Drives inputs on the
// falling edge, samples outputs on the falling edge, and compares against a
// behavioural grid model computed with plain integer arithmetic.
module tb_cnn_grid_sequencer;
  localparam int WIDTH  = 9;
  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int ITER_W = 8;
  localparam int N      = ROWS * COLS;
  localparam int AW     = 4;
  localparam int YW     = 2 * WIDTH;
  localparam int Y_HI   = 131071;
  localparam int Y_LO   = -131072;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic [ITER_W-1:0]   iterations = '0;
  logic [9*WIDTH-1:0]  a_tmpl = '0;
  logic [9*WIDTH-1:0]  b_tmpl = '0;
  logic [WIDTH-1:0]    bias = '0;
  logic [YW-1:0]       init_x = '0;
  logic                u_wr_en = 1'b0;
  logic [AW-1:0]       u_wr_addr = '0;
  logic [WIDTH-1:0]    u_wr_data = '0;
  logic [AW-1:0]       y_rd_addr = '0;
  logic [YW-1:0]       y_rd_data;
  logic                busy;
  logic                done;

  int errors = 0;
  int checks = 0;
  int u_model [N];
  int exp_y   [N];
  int prev_y  [N];
  int a_k [9];
  int b_k [9];

  cnn_grid_sequencer #(.WIDTH(WIDTH), .ROWS(ROWS), .COLS(COLS), .ITER_W(ITER_W)) dut (
    .clk(clk), .rst(rst), .start(start), .iterations(iterations),
    .a_tmpl(a_tmpl), .b_tmpl(b_tmpl), .bias(bias), .init_x(init_x),
    .u_wr_en(u_wr_en), .u_wr_addr(u_wr_addr), .u_wr_data(u_wr_data),
    .y_rd_addr(y_rd_addr), .y_rd_data(y_rd_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic int sat(input longint v);
    if (v > Y_HI) return Y_HI;
    if (v < Y_LO) return Y_LO;
    return int'(v);
  endfunction

  // Reference: synchronous sweeps over the grid, zero outside the grid.
  task automatic model_run(input int iters, input int bias_v, input int init_v);
    int y_old [N];
    int y_new [N];
    for (int i = 0; i < N; i++) y_old[i] = init_v;
    for (int s = 0; s < iters; s++) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          longint acc;
          acc = bias_v;
          for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
              int rr, cc, k;
              rr = r + dr;
              cc = c + dc;
              k  = (dr + 1) * 3 + (dc + 1);
              if (rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS) begin
                acc += longint'(a_k[k]) * y_old[rr*COLS+cc];
                acc += longint'(b_k[k]) * u_model[rr*COLS+cc];
              end
            end
          end
          y_new[r*COLS+c] = sat(acc);
        end
      end
      for (int i = 0; i < N; i++) y_old[i] = y_new[i];
    end
    for (int i = 0; i < N; i++) exp_y[i] = y_old[i];
  endtask

  task automatic clear_tmpl();
    for (int k = 0; k < 9; k++) begin
      a_k[k] = 0;
      b_k[k] = 0;
    end
  endtask

  task automatic write_u(input int addr, input int val);
    @(negedge clk);
    u_wr_en   = 1'b1;
    u_wr_addr = addr[AW-1:0];
    u_wr_data = val[WIDTH-1:0];
    u_model[addr] = val;
    @(negedge clk);
    u_wr_en = 1'b0;
  endtask

  task automatic read_y(input int addr, output int val);
    @(negedge clk);
    y_rd_addr = addr[AW-1:0];
    @(negedge clk);
    val = int'($signed(y_rd_data));
  endtask

  task automatic drive_params(input int iters, input int bias_v, input int init_v);
    for (int k = 0; k < 9; k++) begin
      a_tmpl[k*WIDTH +: WIDTH] = a_k[k][WIDTH-1:0];
      b_tmpl[k*WIDTH +: WIDTH] = b_k[k][WIDTH-1:0];
    end
    bias       = bias_v[WIDTH-1:0];
    init_x     = init_v[YW-1:0];
    iterations = iters[ITER_W-1:0];
  endtask

  // Issue one run, scramble the parameter inputs after accept, and wait for
  // done. lat = cycles from the accept cycle to done (-1 on timeout).
  task automatic run(input int iters, input int bias_v, input int init_v,
                     output int lat, output logic busy_at_load);
    @(negedge clk);
    drive_params(iters, bias_v, init_v);
    start = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    a_tmpl     = {$urandom, $urandom, $urandom};
    b_tmpl     = {$urandom, $urandom, $urandom};
    bias       = WIDTH'($urandom);
    init_x     = YW'($urandom);
    iterations = ITER_W'($urandom);
    busy_at_load = busy;
    lat = 1;
    while (!done && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    if (!done) lat = -1;
  endtask

  task automatic test_reset();
    int v;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", done); end
    checks++;
    if (y_rd_data !== '0) begin errors++; $display("FAIL reset_rd got %0h expected 0", y_rd_data); end
    for (int i = 0; i < N; i++) begin
      u_model[i] = 0;
      exp_y[i]   = 0;
    end
    for (int i = 0; i < N; i += 5) begin
      read_y(i, v);
      checks++;
      if (v !== 0) begin errors++; $display("FAIL reset_y cell %0d got %0d expected 0", i, v); end
    end
  endtask

  task automatic test_hold_identity();
    int lat, v;
    logic bl;
    clear_tmpl();
    a_k[4] = 1;
    model_run(3, 0, 5);
    run(3, 0, 5, lat, bl);
    checks++;
    if (lat !== 3*(N+1)+2) begin errors++; $display("FAIL hold_latency got %0d expected %0d", lat, 3*(N+1)+2); end
    checks++;
    if (bl !== 1'b1) begin errors++; $display("FAIL hold_busy_load got %b expected 1", bl); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL hold_busy_at_done got %b expected 0", busy); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL hold_done_pulse got %b expected 0", done); end
    for (int i = 0; i < N; i++) begin
      read_y(i, v);
      checks++;
      if (v !== 5 || v !== exp_y[i]) begin errors++; $display("FAIL hold_y cell %0d got %0d expected 5", i, v); end
    end
  endtask

  task automatic test_padding();
    int lat, v;
    logic bl;
    for (int i = 0; i < N; i++) write_u(i, 1);
    clear_tmpl();
    for (int k = 0; k < 9; k++) b_k[k] = 1;
    model_run(1, 0, 0);
    run(1, 0, 0, lat, bl);
    checks++;
    if (lat !== (N+1)+2) begin errors++; $display("FAIL pad_latency got %0d expected %0d", lat, N+3); end
    for (int i = 0; i < N; i++) begin
      read_y(i, v);
      checks++;
      if (v !== exp_y[i]) begin errors++; $display("FAIL pad_y cell %0d got %0d expected %0d", i, v, exp_y[i]); end
    end
  endtask

  task automatic test_bias_and_zero_iter();
    int lat, v;
    logic bl;
    clear_tmpl();
    run(1, -7, 0, lat, bl);
    for (int i = 0; i < N; i++) begin
      read_y(i, v);
      checks++;
      if (v !== -7) begin errors++; $display("FAIL bias_y cell %0d got %0d expected -7", i, v); end
    end
    a_k[4] = 3;
    run(0, 0, 12, lat, bl);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL zero_iter_latency got %0d expected 2", lat); end
    for (int i = 0; i < N; i += 3) begin
      read_y(i, v);
      checks++;
      if (v !== 12) begin errors++; $display("FAIL zero_iter_y cell %0d got %0d expected 12", i, v); end
    end
  endtask

  task automatic test_saturation();
    int lat, v;
    logic bl;
    clear_tmpl();
    a_k[4] = 255;
    run(2, 0, 1000, lat, bl);
    for (int i = 0; i < N; i++) begin
      read_y(i, v);
      checks++;
      if (v !== Y_HI) begin errors++; $display("FAIL sat_hi cell %0d got %0d expected %0d", i, v, Y_HI); end
    end
    run(2, 0, -1000, lat, bl);
    for (int i = 0; i < N; i++) begin
      read_y(i, v);
      checks++;
      if (v !== Y_LO) begin errors++; $display("FAIL sat_lo cell %0d got %0d expected %0d", i, v, Y_LO); end
    end
  endtask

  task automatic test_jacobi();
    int lat, v, want;
    logic bl;
    clear_tmpl();
    a_k[3] = 1;
    run(2, 0, 1, lat, bl);
    for (int i = 0; i < N; i++) begin
      want = (i % COLS >= 2) ? 1 : 0;
      read_y(i, v);
      checks++;
      if (v !== want) begin errors++; $display("FAIL jacobi cell %0d got %0d expected %0d", i, v, want); end
    end
  endtask

  task automatic test_random();
    int lat, v, iters, bias_v, init_v;
    logic bl;
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < N; i++) write_u(i, int'($urandom_range(100)) - 50);
      for (int k = 0; k < 9; k++) begin
        a_k[k] = int'($urandom_range(6)) - 3;
        b_k[k] = int'($urandom_range(6)) - 3;
      end
      iters  = int'($urandom_range(3, 1));
      bias_v = int'($urandom_range(40)) - 20;
      init_v = int'($urandom_range(60)) - 30;
      model_run(iters, bias_v, init_v);
      run(iters, bias_v, init_v, lat, bl);
      checks++;
      if (lat !== iters*(N+1)+2) begin errors++; $display("FAIL rand_latency run %0d got %0d expected %0d", t, lat, iters*(N+1)+2); end
      for (int i = 0; i < N; i++) begin
        read_y(i, v);
        checks++;
        if (v !== exp_y[i]) begin errors++; $display("FAIL rand_y run %0d cell %0d got %0d expected %0d", t, i, v, exp_y[i]); end
      end
    end
  endtask

  // start and U writes held high while busy must be ignored; readout must
  // keep showing the previous run's results throughout.
  task automatic test_busy_ignore();
    int n, v, prev_addr, lat_exp, busy_bad;
    for (int i = 0; i < N; i++) prev_y[i] = exp_y[i];
    for (int k = 0; k < 9; k++) begin
      a_k[k] = int'($urandom_range(4)) - 2;
      b_k[k] = int'($urandom_range(4)) - 2;
    end
    model_run(2, 3, -4);
    lat_exp = 2 * (N + 1) + 2;
    @(negedge clk);
    drive_params(2, 3, -4);
    start = 1'b1;
    @(negedge clk);
    n = 1;
    prev_addr = -1;
    while (!done && n < 400) begin
      if (prev_addr >= 0) begin
        v = int'($signed(y_rd_data));
        checks++;
        if (v !== prev_y[prev_addr]) begin errors++; $display("FAIL busy_readout cycle %0d got %0d expected %0d", n, v, prev_y[prev_addr]); end
      end
      if (n < lat_exp - 1) begin
        start     = 1'b1;
        u_wr_en   = 1'b1;
        u_wr_addr = AW'($urandom);
        u_wr_data = WIDTH'($urandom);
      end else begin
        start   = 1'b0;
        u_wr_en = 1'b0;
      end
      y_rd_addr = AW'(n % N);
      prev_addr = n % N;
      @(negedge clk);
      n++;
    end
    start   = 1'b0;
    u_wr_en = 1'b0;
    checks++;
    if (n !== lat_exp) begin errors++; $display("FAIL busy_latency got %0d expected %0d", n, lat_exp); end
    busy_bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0) busy_bad++;
    end
    checks++;
    if (busy_bad !== 0) begin errors++; $display("FAIL busy_no_queue got %0d active cycles expected 0", busy_bad); end
    for (int i = 0; i < N; i++) begin
      read_y(i, v);
      checks++;
      if (v !== exp_y[i]) begin errors++; $display("FAIL busy_result cell %0d got %0d expected %0d", i, v, exp_y[i]); end
    end
  endtask

  task automatic test_reset_abort();
    int v, done_seen, lat;
    logic bl;
    for (int i = 0; i < N; i++) write_u(i, int'($urandom_range(60)) + 1);
    clear_tmpl();
    b_k[4] = 1;
    @(negedge clk);
    drive_params(3, 0, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b expected 0", busy); end
    done_seen = 0;
    repeat (70) begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
    end
    checks++;
    if (done_seen !== 0) begin errors++; $display("FAIL abort_done got %0d pulses expected 0", done_seen); end
    for (int i = 0; i < N; i++) begin
      read_y(i, v);
      checks++;
      if (v !== 0) begin errors++; $display("FAIL abort_y cell %0d got %0d expected 0", i, v); end
    end
    for (int i = 0; i < N; i++) u_model[i] = 0;
    model_run(1, 0, 0);
    run(1, 0, 0, lat, bl);
    for (int i = 0; i < N; i++) begin
      read_y(i, v);
      checks++;
      if (v !== exp_y[i]) begin errors++; $display("FAIL abort_u cell %0d got %0d expected %0d", i, v, exp_y[i]); end
    end
  endtask

  initial begin
    clear_tmpl();
    test_reset();
    test_hold_identity();
    test_padding();
    test_bias_and_zero_iter();
    test_saturation();
    test_jacobi();
    test_random();
    test_busy_ignore();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cnn_grid_sequencer.md
Name: cnn_grid_sequencer

Overview:
Parametrised ROWS x COLS cellular-network grid engine: time-multiplexes one 3x3 template cell over every grid cell, in raster order, for a programmable number of synchronous sweeps. Holds input image U and state Y in internal arrays, uses zero padding at grid edges, and double-buffers Y so every sweep reads only previous-sweep values. Sits between the image loader and the readout logic; it succeeds the fixed 4x4, free-running, no-reset sequencer.

Parameters:
WIDTH, 9, signed width of template coefficients, U, bias I; Y/state are 2*WIDTH signed
ROWS, 4, grid rows (>=2)
COLS, 4, grid columns (>=2)
ITER_W, 8, width of iteration count
(local) N = ROWS*COLS; ADDR_W = clog2(N); ACC_W = 3*WIDTH+5

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  request run; accepted only when idle
iterations  in  ITER_W  number of sweeps, sampled at accept
a_tmpl  in  9*WIDTH  feedback template; slice k*WIDTH+:WIDTH = A(k+1), row-major, A5 centre, A1 = (r-1,c-1)
b_tmpl  in  9*WIDTH  control template, same layout, applied to U
bias  in  WIDTH  bias I, signed
init_x  in  2*WIDTH  initial Y for every cell, signed
u_wr_en  in  1  write U cell
u_wr_addr  in  ADDR_W  U address, r*COLS+c
u_wr_data  in  WIDTH  U value
y_rd_addr  in  ADDR_W  Y read address
y_rd_data  out  2*WIDTH  registered Y from last completed bank, 1-cycle read latency
busy  out  1  run in progress
done  out  1  one-cycle pulse at run completion

Behaviour:
- Reset: FSM to IDLE; busy=0, done=0, y_rd_data=0; both Y banks and U array cleared to 0; captured templates/bias/count cleared. Reset mid-run aborts immediately; no partial results kept.
- FSM: IDLE -> (start) LOAD -> SWEEP -> DRAIN -> (more sweeps ? SWEEP : FIN) -> IDLE.
- Accept (IDLE, start=1): latch a_tmpl, b_tmpl, bias, iterations. LOAD (1 cycle): read bank := init_x in all N cells; busy=1. iterations=0: LOAD -> FIN directly, result = init_x everywhere.
- SWEEP: cell index 0..N-1, one per cycle. Cell (r,c): acc = sum_k A(k)*Y_read(nbr_k) + sum_k B(k)*U(nbr_k) + bias, nbr offsets in {-1,0,1}^2; out-of-grid neighbours contribute 0 for both Y and U. Products and sum signed, ACC_W wide, no intermediate overflow.
- Result saturated to 2*WIDTH signed range [-2^(2W-1), 2^(2W-1)-1], written to write bank one cycle after issue. DRAIN = 1 cycle for last write; then banks swap. Sweep cost N+1 cycles.
- FIN: busy=0, done=1 for exactly one cycle; last-written bank becomes readout bank. Start accepted at accept cycle t => done at t+2+K*(N+1) for K>0 sweeps (t+2 for K=0).
- While busy: start ignored (no queueing), u_wr_en ignored, y_rd_data returns bank completed by the previous run (stable, not mid-sweep data). In IDLE, U writes take effect next cycle; readout bank unchanged by U writes.
- start and done in the same cycle: done is in FIN, start accepted next cycle only if still high in IDLE.
- Template/bias/init_x changes while busy have no effect.

Test Plan:
- 4x4, A5=1 others 0, B=0, bias=0, init_x=5, iterations=3 -> all Y=5; done exactly 3*17+2 cycles after accept, busy low same cycle.
- 4x4, A=0, all B=1, U all 1, bias=0, iterations=1 -> corners 4, edges 6, interior 9 (zero padding check).
- A=0, B=0, bias=-7, iterations=1 -> all Y=-7 (0x3FFF9); iterations=0 with init_x=12 -> all Y=12, done 2 cycles after accept.
- A5=255, B=0, init_x=1000, iterations=2 -> all Y=131071; repeat init_x=-1000 -> all Y=-131072.
- Jacobi: A4=1 (left neighbour) only, init_x=1, iterations=2 -> columns 0,1 = 0, columns 2,3 = 1 (proves reads use prior sweep only).
- Mid-sweep: assert start, u_wr_en again while busy -> ignored; assert rst at sweep cycle 5 -> busy=0, done never pulses, all Y reads 0, U reads back 0 after re-run with B5=1.
